// File: rtl/param_ins_cache.sv
// param_ins_cache: N-way set-associative true-LRU instruction cache with next-level miss handshake
module param_ins_cache #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = 6,
    parameter int SET_BITS    = 14,
    parameter int WAYS        = 4,
    parameter int CNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    input  logic [3:0]                    n,
    input  logic [ADDR_W-1:0]             add_in,
    output logic                          cmd_ready,
    output logic                          resp_valid,
    output logic                          resp_hit,
    output logic                          l2_req,
    output logic [ADDR_W-OFFSET_BITS-1:0] l2_addr,
    input  logic                          l2_ack,
    output logic [CNT_W-1:0]              hits,
    output logic [CNT_W-1:0]              misses,
    output logic [CNT_W-1:0]              reads
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - SET_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {CLEAR, IDLE, MISS} state_t;
    state_t state, nxt;

    logic [WAYS-1:0]  valid   [SETS];
    logic [TAG_W-1:0] tag_mem [SETS][WAYS];
    logic [AGE_W-1:0] age     [SETS][WAYS];
    logic [AGE_W-1:0] new_age [WAYS];

    logic [SET_BITS-1:0]           clr_idx, idx, m_idx, t_set;
    logic [TAG_W-1:0]              tg, m_tag;
    logic [ADDR_W-OFFSET_BITS-1:0] miss_addr;
    logic [AGE_W-1:0]              hit_way, vic, t_way, cur_age;
    logic                          acc, fetch, inval, rcmd, fill, hit, unused_offset;

    assign idx           = add_in[SET_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign tg            = add_in[ADDR_W-1:SET_BITS+OFFSET_BITS];
    assign m_idx         = miss_addr[SET_BITS-1:0];
    assign m_tag         = miss_addr[ADDR_W-OFFSET_BITS-1:SET_BITS];
    assign unused_offset = ^add_in[OFFSET_BITS-1:0];
    assign cmd_ready     = state == IDLE;
    assign acc           = cmd_valid && cmd_ready;
    assign fetch         = acc && n == 4'd2;
    assign inval         = acc && n == 4'd3;
    assign rcmd          = acc && n == 4'd8;
    assign fill          = state == MISS && l2_ack;
    assign l2_req        = state == MISS;
    assign l2_addr       = l2_req ? miss_addr : '1;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tag_mem[idx][w] == tg) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (age[m_idx][w] == AGE_W'(WAYS - 1)) vic = AGE_W'(w);
        end
        // Any invalid way beats the LRU way; scanning downward leaves the lowest one.
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[m_idx][w]) vic = AGE_W'(w);
        t_set   = fill ? m_idx : idx;
        t_way   = fill ? vic : hit_way;
        cur_age = age[t_set][t_way];
        for (int w = 0; w < WAYS; w++)
            new_age[w] = AGE_W'(w) == t_way ? '0 :
                         age[t_set][w] < cur_age ? age[t_set][w] + 1'b1 : age[t_set][w];
    end

    always_comb
        nxt = state == CLEAR ? (&clr_idx ? IDLE : CLEAR) :
              state == MISS  ? (l2_ack ? IDLE : MISS) :
              rcmd           ? CLEAR :
              fetch && !hit  ? MISS : IDLE;

    always_ff @(posedge clk)
        state <= rst ? CLEAR : nxt;

    always_ff @(posedge clk) begin
        if (rst || rcmd) begin
            clr_idx    <= '0;
            hits       <= '0;
            misses     <= '0;
            reads      <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
        end else begin
            clr_idx    <= state == CLEAR ? clr_idx + 1'b1 : '0;
            resp_valid <= (fetch && hit) || fill;
            resp_hit   <= fetch && hit;
            if (fetch) begin
                reads     <= reads + 1'b1;
                hits      <= hits + CNT_W'(hit);
                misses    <= misses + CNT_W'(!hit);
                miss_addr <= add_in[ADDR_W-1:OFFSET_BITS];
            end
        end
    end

    // Reset also blocks a fill from an ack arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                valid[clr_idx] <= '0;
                for (int w = 0; w < WAYS; w++) age[clr_idx][w] <= AGE_W'(w);
            end
            if (inval && hit) valid[idx][hit_way] <= 1'b0;
            if (fill) begin
                tag_mem[m_idx][vic] <= m_tag;
                valid[m_idx][vic]   <= 1'b1;
            end
            if (fill || (fetch && hit))
                for (int w = 0; w < WAYS; w++) age[t_set][w] <= new_age[w];
        end
    end
endmodule

// File: tb/tb_param_ins_cache.sv
// tb_param_ins_cache: directed scoreboard bench for param_ins_cache (4 sets, 4 ways, 64-byte lines)
module tb_param_ins_cache;
    logic        clk, rst, cmd_valid, cmd_ready, resp_valid, resp_hit, l2_req, l2_ack;
    logic [3:0]  n;
    logic [31:0] add_in, hits, misses, reads;
    logic [25:0] l2_addr;
    logic        auto_ack, man_ack;

    int n_assert = 0, n_fail = 0, resp_cnt = 0, cyc;
    int exp_reads = 0, exp_hits = 0, exp_misses = 0;
    bit sb [$];
    logic [23:0] mdl [4][$];

    param_ins_cache #(.ADDR_W(32), .OFFSET_BITS(6), .SET_BITS(2), .WAYS(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .n(n), .add_in(add_in),
        .cmd_ready(cmd_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .l2_req(l2_req), .l2_addr(l2_addr), .l2_ack(l2_ack),
        .hits(hits), .misses(misses), .reads(reads)
    );

    assign l2_ack = auto_ack ? l2_req : man_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per-set tag list ordered most- to least-recently used.
    function automatic bit mdl_access(input logic [31:0] a);
        int s;
        s = int'(a[7:6]);
        for (int i = 0; i < mdl[s].size(); i++)
            if (mdl[s][i] == a[31:8]) begin
                mdl[s].delete(i);
                mdl[s].push_front(a[31:8]);
                return 1'b1;
            end
        mdl[s].push_front(a[31:8]);
        if (mdl[s].size() > 4) void'(mdl[s].pop_back());
        return 1'b0;
    endfunction

    function automatic void mdl_inval(input logic [31:0] a);
        int s;
        s = int'(a[7:6]);
        for (int i = 0; i < mdl[s].size(); i++)
            if (mdl[s][i] == a[31:8]) begin
                mdl[s].delete(i);
                return;
            end
    endfunction

    function automatic void mdl_clear();
        for (int s = 0; s < 4; s++) mdl[s].delete();
        sb.delete();
        exp_reads = 0;
        exp_hits = 0;
        exp_misses = 0;
    endfunction

    task automatic send(input logic [3:0] c, input logic [31:0] a);
        int t;
        bit h;
        t = 0;
        cmd_valid = 1'b1;
        n = c;
        add_in = a;
        while (!cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("accept", cmd_ready, 1'b1);
        if (c == 4'd2) begin
            h = mdl_access(a);
            sb.push_back(h);
            exp_reads++;
            if (h) exp_hits++;
            else exp_misses++;
        end else if (c == 4'd3) mdl_inval(a);
        else if (c == 4'd8) mdl_clear();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(output int c);
        c = 0;
        while (!cmd_ready && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_reads"}, reads, exp_reads);
        chk({tag, "_hits"}, hits, exp_hits);
        chk({tag, "_misses"}, misses, exp_misses);
    endtask

    always @(negedge clk)
        if (resp_valid) begin
            resp_cnt++;
            chk("resp_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) chk("resp_hit", resp_hit, sb.pop_front());
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; n = 4'd0; add_in = '0; auto_ack = 1'b0; man_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_l2_req", l2_req, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk_counts("rst");
        wait_ready(cyc);
        chk("rst_sweep_cycles", cyc, 4);

        // Cold miss with a stalled acknowledge
        send(4'd2, 32'h0000_0040);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("miss_l2_req", l2_req, 1'b1);
            chk("miss_l2_addr", l2_addr, 26'h000_0001);
            @(posedge clk); #1;
        end
        man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        chk("miss_resp_valid", resp_valid, 1'b1);
        chk("miss_resp_hit", resp_hit, 1'b0);
        chk("miss_l2_req_drop", l2_req, 1'b0);
        chk("miss_l2_addr_idle", l2_addr, 26'h3FF_FFFF);
        chk("miss_count", misses, 1);
        send(4'd2, 32'h0000_0044);
        cmd_valid = 1'b0;
        chk("hit_resp_valid", resp_valid, 1'b1);
        chk("hit_resp_hit", resp_hit, 1'b1);
        chk("hit_no_l2_req", l2_req, 1'b0);
        chk("hit_count", hits, 1);
        drain();
        chk_counts("cold");

        // LRU eviction in set 0
        auto_ack = 1'b1;
        send(4'd2, 32'h0000_0100);
        send(4'd2, 32'h0000_0200);
        send(4'd2, 32'h0000_0300);
        send(4'd2, 32'h0000_0400);
        send(4'd2, 32'h0000_0100);
        send(4'd2, 32'h0000_0500);
        send(4'd2, 32'h0000_0100);
        send(4'd2, 32'h0000_0200);
        cmd_valid = 1'b0;
        drain();
        chk_counts("lru");

        // Invalidate, then refetch must go to the next level
        send(4'd2, 32'h0010_0000);
        send(4'd3, 32'h0010_0000);
        cmd_valid = 1'b0;
        chk("inval_no_resp", resp_valid, 1'b0);
        send(4'd2, 32'h0010_0000);
        cmd_valid = 1'b0;
        chk("inval_refetch_l2_req", l2_req, 1'b1);
        drain();
        chk_counts("inval");
        send(4'd3, 32'h00AB_CD00);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk_counts("inval_absent");

        // Reset during an outstanding miss, with a late acknowledge
        auto_ack = 1'b0;
        send(4'd2, 32'h0000_0080);
        cmd_valid = 1'b0;
        chk("rmiss_l2_req", l2_req, 1'b1);
        rst = 1'b1;
        man_ack = 1'b1;
        mdl_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rmiss_l2_req_drop", l2_req, 1'b0);
        chk("rmiss_resp_valid", resp_valid, 1'b0);
        chk("rmiss_ready", cmd_ready, 1'b0);
        chk_counts("rmiss");
        wait_ready(cyc);
        chk("rmiss_sweep_cycles", cyc, 4);
        man_ack = 1'b0;
        auto_ack = 1'b1;
        send(4'd2, 32'h0000_0080);
        cmd_valid = 1'b0;
        drain();
        chk_counts("rmiss_after");

        // RESET command, then back-to-back fetches
        send(4'd8, 32'h0);
        cmd_valid = 1'b0;
        chk("rcmd_ready", cmd_ready, 1'b0);
        chk_counts("rcmd");
        wait_ready(cyc);
        chk("rcmd_sweep_cycles", cyc, 4);
        resp_cnt = 0;
        send(4'd2, 32'h0000_0100);
        send(4'd2, 32'h0000_0100);
        send(4'd2, 32'h0000_0140);
        send(4'd2, 32'h0000_0200);
        send(4'd2, 32'h0000_0140);
        send(4'd2, 32'h0000_03C0);
        cmd_valid = 1'b0;
        drain();
        chk("b2b_reads", reads, 6);
        chk("b2b_sum", hits + misses, 6);
        chk_counts("b2b");
        chk("b2b_resp_pulses", resp_cnt, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
